rv32v_vmem_sequencer: RTL and testbench

- Element-level sequencer for vector unit-stride and strided loads and stores in the rv32v memory stage.
- Accepts one vector memory op, walks elements 0..vl-1, and issues one scalar-width request per active element to the load-store controller (LSC) handshake.
- Skips masked-off elements, steers load data to the correct lane for writeback, and reports completion and faults to the hazard unit.

---
 rtl/rv32v_types_pkg.sv | 37 +++
 rtl/rv32v_vmem_addr_gen.sv | 40 ++++
 rtl/rv32v_vmem_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_rv32v_vmem_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32v_types_pkg.sv
// Shared types for the rv32v vector memory sequencer: FSM states, element
// width encoding and the LSC load-type encoding.
package rv32v_types_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_DONE   = 2'b10,
    ST_FAULT  = 2'b11
  } vmem_seq_state_t;

  typedef enum logic [1:0] {
    EEW_8   = 2'b00,
    EEW_16  = 2'b01,
    EEW_32  = 2'b10,
    EEW_RSV = 2'b11
  } veew_t;

  // Matches the scalar load funct3 encoding used by the LSC.
  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_t;

  // Vector elements are zero-extended; the reserved width behaves as 32b.
  function automatic load_t eew_to_load_t(input veew_t eew);
    case (eew)
      EEW_8:   return LD_LBU;
      EEW_16:  return LD_LHU;
      default: return LD_LW;
    endcase
  endfunction

endpackage

// File: rtl/rv32v_vmem_addr_gen.sv
// Element address accumulator (base + n*stride, wrapping) with the
// element-width alignment check for the current address.
module rv32v_vmem_addr_gen
  import rv32v_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        clr,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] base_addr,
  input  logic [31:0] stride,
  input  veew_t       eew,
  output logic [31:0] addr,
  output logic        mal
);

  logic [31:0] stride_q;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      addr     <= '0;
      stride_q <= '0;
    end else if (load) begin
      addr     <= base_addr;
      stride_q <= stride;
    end else if (advance) begin
      addr     <= addr + stride_q;
    end
  end

  always_comb begin
    case (eew)
      EEW_8:   mal = 1'b0;
      EEW_16:  mal = addr[0];
      default: mal = |addr[1:0];
    endcase
  end

endmodule

// File: rtl/rv32v_vmem_sequencer.sv
// Element sequencer for unit-stride/strided vector loads and stores: walks
// elements 0..vl-1 and issues one scalar request per active element.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; no requests
// ST_ACTIVE | walking elements; request held until lsc_ready
// ST_DONE   | one-cycle done pulse, then back to idle
// ST_FAULT  | misaligned or bus error recorded; held until flush
module rv32v_vmem_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int VL_W      = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic                         is_store,
  input  logic [31:0]                  base_addr,
  input  logic [31:0]                  stride,
  input  logic [1:0]                   eew,
  input  logic [VL_W-1:0]              vl,
  input  logic                         mask_en,
  input  logic                         elem_mask,
  input  logic [31:0]                  elem_store_data,
  input  logic                         flush,
  input  logic                         lsc_ready,
  input  logic                         lsc_error,
  input  logic [31:0]                  lsc_load_data,
  output logic                         lsc_ren,
  output logic                         lsc_wen,
  output logic [31:0]                  lsc_addr,
  output logic [31:0]                  lsc_store_data,
  output logic [2:0]                   lsc_load_type,
  output logic [VL_W-1:0]              elem_idx,
  output logic                         wb_valid,
  output logic [$clog2(NUM_LANES)-1:0] wb_lane,
  output logic [VL_W-1:0]              wb_elem_idx,
  output logic [31:0]                  wb_data,
  output logic                         busy,
  output logic                         done,
  output logic                         fault,
  output logic                         fault_mal,
  output logic [31:0]                  fault_addr,
  output logic [VL_W-1:0]              fault_elem
);

  localparam int LANE_W = $clog2(NUM_LANES);

  vmem_seq_state_t state_q, state_d;
  logic            is_store_q;
  logic            mask_en_q;
  veew_t           eew_q;
  logic [VL_W-1:0] vl_q;
  logic [VL_W-1:0] elem_idx_q;
  logic            fault_q;
  logic            fault_mal_q;
  logic [31:0]     fault_addr_q;
  logic [VL_W-1:0] fault_elem_q;

  logic            load_op;
  logic            advance;
  logic            step;
  logic            set_fault;
  logic            set_mal;
  logic            elem_active;
  logic            last_elem;
  logic [31:0]     addr;
  logic            mal;

  rv32v_vmem_addr_gen u_addr_gen (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (flush),
    .load      (load_op),
    .advance   (advance),
    .base_addr (base_addr),
    .stride    (stride),
    .eew       (eew_q),
    .addr      (addr),
    .mal       (mal)
  );

  assign elem_active = ~mask_en_q | elem_mask;
  assign last_elem   = (elem_idx_q == vl_q - VL_W'(1));

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      state_q      <= ST_IDLE;
      elem_idx_q   <= '0;
      fault_q      <= 1'b0;
      fault_mal_q  <= 1'b0;
      fault_addr_q <= '0;
      fault_elem_q <= '0;
      if (RST) begin
        is_store_q <= 1'b0;
        mask_en_q  <= 1'b0;
        eew_q      <= EEW_8;
        vl_q       <= '0;
      end
    end else begin
      state_q <= state_d;
      if (load_op) begin
        is_store_q <= is_store;
        mask_en_q  <= mask_en;
        eew_q      <= veew_t'(eew);
        vl_q       <= vl;
        elem_idx_q <= '0;
      end else if (advance) begin
        elem_idx_q <= elem_idx_q + VL_W'(1);
      end
      if (set_fault) begin
        fault_q      <= 1'b1;
        fault_mal_q  <= set_mal;
        fault_addr_q <= addr;
        fault_elem_q <= elem_idx_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    load_op   = 1'b0;
    advance   = 1'b0;
    step      = 1'b0;
    set_fault = 1'b0;
    set_mal   = 1'b0;
    lsc_ren   = 1'b0;
    lsc_wen   = 1'b0;
    wb_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_op = 1'b1;
          state_d = (vl == '0) ? ST_DONE : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!elem_active) begin
          step = 1'b1;
        end else if (mal) begin
          set_fault = 1'b1;
          set_mal   = 1'b1;
          state_d   = ST_FAULT;
        end else begin
          lsc_ren = ~is_store_q;
          lsc_wen = is_store_q;
          if (lsc_ready) begin
            if (lsc_error) begin
              set_fault = 1'b1;
              state_d   = ST_FAULT;
            end else begin
              wb_valid = ~is_store_q;
              step     = 1'b1;
            end
          end
        end
        if (step) begin
          if (last_elem) state_d = ST_DONE;
          else           advance = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
    // Flush wins over everything, including a completing request.
    if (flush) begin
      state_d   = ST_IDLE;
      load_op   = 1'b0;
      advance   = 1'b0;
      set_fault = 1'b0;
      lsc_ren   = 1'b0;
      lsc_wen   = 1'b0;
      wb_valid  = 1'b0;
    end
  end

  assign lsc_addr       = addr;
  assign lsc_store_data = lsc_wen ? elem_store_data : '0;
  assign lsc_load_type  = lsc_ren ? eew_to_load_t(eew_q) : 3'b000;
  assign elem_idx       = elem_idx_q;

  assign wb_lane     = wb_valid ? elem_idx_q[LANE_W-1:0] : '0;
  assign wb_elem_idx = wb_valid ? elem_idx_q : '0;
  assign wb_data     = wb_valid ? lsc_load_data : '0;

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign fault      = fault_q;
  assign fault_mal  = fault_mal_q;
  assign fault_addr = fault_addr_q;
  assign fault_elem = fault_elem_q;

endmodule

// File: tb/tb_rv32v_vmem_sequencer.sv
// Directed bench for rv32v_vmem_sequencer with hand-computed expectations.
module tb_rv32v_vmem_sequencer;

  logic        CLK;
  logic        RST;
  logic        start;
  logic        is_store;
  logic [31:0] base_addr;
  logic [31:0] stride;
  logic [1:0]  eew;
  logic [7:0]  vl;
  logic        mask_en;
  logic        elem_mask;
  logic [31:0] elem_store_data;
  logic        flush;
  logic        lsc_ready;
  logic        lsc_error;
  logic [31:0] lsc_load_data;
  logic        lsc_ren;
  logic        lsc_wen;
  logic [31:0] lsc_addr;
  logic [31:0] lsc_store_data;
  logic [2:0]  lsc_load_type;
  logic [7:0]  elem_idx;
  logic        wb_valid;
  logic [1:0]  wb_lane;
  logic [7:0]  wb_elem_idx;
  logic [31:0] wb_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic        fault_mal;
  logic [31:0] fault_addr;
  logic [7:0]  fault_elem;

  int n_tests = 0;
  int n_fail  = 0;

  rv32v_vmem_sequencer #(.NUM_LANES(4), .VL_W(8)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .start           (start),
    .is_store        (is_store),
    .base_addr       (base_addr),
    .stride          (stride),
    .eew             (eew),
    .vl              (vl),
    .mask_en         (mask_en),
    .elem_mask       (elem_mask),
    .elem_store_data (elem_store_data),
    .flush           (flush),
    .lsc_ready       (lsc_ready),
    .lsc_error       (lsc_error),
    .lsc_load_data   (lsc_load_data),
    .lsc_ren         (lsc_ren),
    .lsc_wen         (lsc_wen),
    .lsc_addr        (lsc_addr),
    .lsc_store_data  (lsc_store_data),
    .lsc_load_type   (lsc_load_type),
    .elem_idx        (elem_idx),
    .wb_valid        (wb_valid),
    .wb_lane         (wb_lane),
    .wb_elem_idx     (wb_elem_idx),
    .wb_data         (wb_data),
    .busy            (busy),
    .done            (done),
    .fault           (fault),
    .fault_mal       (fault_mal),
    .fault_addr      (fault_addr),
    .fault_elem      (fault_elem)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow at +3.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic start_op(input logic st, input logic [31:0] base, input logic [31:0] strd,
                          input logic [1:0] w, input logic [7:0] n, input logic men);
    is_store  = st;
    base_addr = base;
    stride    = strd;
    eew       = w;
    vl        = n;
    mask_en   = men;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  initial begin
    RST = 1'b1; start = 0; is_store = 0; base_addr = 0; stride = 0; eew = 0; vl = 0;
    mask_en = 0; elem_mask = 0; elem_store_data = 0; flush = 0;
    lsc_ready = 0; lsc_error = 0; lsc_load_data = 0;
    step(); step();
    RST = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_ren", lsc_ren, 0);
    check("rst_wen", lsc_wen, 0);
    check("rst_addr", lsc_addr, 0);
    check("rst_elem", elem_idx, 0);
    check("rst_wbv", wb_valid, 0);

    // Unit-stride load, ready every cycle; a second start mid-op is ignored.
    start_op(1'b0, 32'h1000, 32'd4, 2'b10, 8'd4, 1'b0);
    lsc_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lsc_load_data = 32'hA500_0000 | k;
      start         = (k == 1);
      base_addr     = (k == 1) ? 32'h5000 : 32'h1000;
      #1;
      check("t1_ren", lsc_ren, 1);
      check("t1_addr", lsc_addr, 32'h1000 + 4 * k);
      check("t1_wbv", wb_valid, 1);
      check("t1_lane", wb_lane, k);
      check("t1_wbidx", wb_elem_idx, k);
      check("t1_wbdata", wb_data, 32'hA500_0000 | k);
      check("t1_ltype", lsc_load_type, 3'b010);
      check("t1_done_early", done, 0);
      step();
    end
    start = 1'b0;
    #1;
    check("t1_done", done, 1);
    check("t1_ren_done", lsc_ren, 0);
    step(); #1;
    check("t1_idle", busy, 0);
    check("t1_done_clr", done, 0);

    // Masked strided store, stride -8, mask 101.
    start_op(1'b1, 32'h3000, 32'hFFFF_FFF8, 2'b10, 8'd3, 1'b1);
    elem_mask = 1'b1; elem_store_data = 32'h11; #1;
    check("t2_wen0", lsc_wen, 1);
    check("t2_ren0", lsc_ren, 0);
    check("t2_addr0", lsc_addr, 32'h3000);
    check("t2_sdata0", lsc_store_data, 32'h11);
    check("t2_wbv0", wb_valid, 0);
    step();
    elem_mask = 1'b0; elem_store_data = 32'h22; #1;
    check("t2_wen1", lsc_wen, 0);
    check("t2_idx1", elem_idx, 1);
    step();
    elem_mask = 1'b1; elem_store_data = 32'h33; #1;
    check("t2_wen2", lsc_wen, 1);
    check("t2_addr2", lsc_addr, 32'h2FF0);
    check("t2_sdata2", lsc_store_data, 32'h33);
    step(); #1;
    check("t2_done", done, 1);
    check("t2_wen_done", lsc_wen, 0);
    step();
    mask_en = 1'b0;

    // Misaligned 16b access.
    start_op(1'b0, 32'h2001, 32'd2, 2'b01, 8'd2, 1'b0);
    #1;
    check("t3_ren", lsc_ren, 0);
    step(); #1;
    check("t3_fault", fault, 1);
    check("t3_mal", fault_mal, 1);
    check("t3_faddr", fault_addr, 32'h2001);
    check("t3_felem", fault_elem, 0);
    step(); step(); #1;
    check("t3_hold_busy", busy, 1);
    check("t3_hold_fault", fault, 1);
    check("t3_hold_ren", lsc_ren, 0);
    flush = 1'b1;
    step();
    flush = 1'b0; #1;
    check("t3_flush_busy", busy, 0);
    check("t3_flush_fault", fault, 0);
    check("t3_flush_faddr", fault_addr, 0);

    // Bus error on element 2 after a three-cycle ready delay.
    start_op(1'b0, 32'h4000, 32'd4, 2'b10, 8'd4, 1'b0);
    lsc_ready = 1'b1; step(); step();
    lsc_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      #1;
      check("t4_wait_ren", lsc_ren, 1);
      check("t4_wait_addr", lsc_addr, 32'h4008);
      check("t4_wait_wbv", wb_valid, 0);
      step();
    end
    lsc_ready = 1'b1; lsc_error = 1'b1; #1;
    check("t4_err_ren", lsc_ren, 1);
    check("t4_err_wbv", wb_valid, 0);
    step();
    lsc_error = 1'b0; lsc_ready = 1'b0; #1;
    check("t4_fault", fault, 1);
    check("t4_mal", fault_mal, 0);
    check("t4_faddr", fault_addr, 32'h4008);
    check("t4_felem", fault_elem, 2);
    flush = 1'b1; step(); flush = 1'b0;

    // vl = 0: done on cycle 1, no requests.
    start_op(1'b0, 32'h9000, 32'd4, 2'b10, 8'd0, 1'b0);
    lsc_ready = 1'b1; #1;
    check("t5_done", done, 1);
    check("t5_ren", lsc_ren, 0);
    check("t5_wen", lsc_wen, 0);
    step(); #1;
    check("t5_idle", busy, 0);

    // Flush while element 1 waits, then restart from element 0.
    start_op(1'b0, 32'h6000, 32'd4, 2'b10, 8'd4, 1'b0);
    step();
    lsc_ready = 1'b0; #1;
    check("t6_wait_idx", elem_idx, 1);
    check("t6_wait_ren", lsc_ren, 1);
    flush = 1'b1; step(); flush = 1'b0; #1;
    check("t6_flush_busy", busy, 0);
    check("t6_flush_ren", lsc_ren, 0);
    check("t6_flush_fault", fault, 0);
    start_op(1'b0, 32'h7000, 32'd4, 2'b10, 8'd4, 1'b0);
    #1;
    check("t6_restart_idx", elem_idx, 0);
    check("t6_restart_addr", lsc_addr, 32'h7000);
    check("t6_restart_ren", lsc_ren, 1);

    // Reset while element 1 waits, then restart.
    lsc_ready = 1'b1; step(); lsc_ready = 1'b0;
    RST = 1'b1; step(); RST = 1'b0; #1;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_ren", lsc_ren, 0);
    check("t7_rst_idx", elem_idx, 0);
    start_op(1'b0, 32'h8000, 32'd4, 2'b00, 8'd2, 1'b0);
    #1;
    check("t7_restart_addr", lsc_addr, 32'h8000);
    check("t7_restart_ren", lsc_ren, 1);
    check("t7_ltype_lbu", lsc_load_type, 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
